// File: rtl/instr_pipe.sv
// instr_pipe: in-flight instruction window for the hazard controller.
//   Slot 0 = fetch reg, slot 1 = decode, slots 2.. = execute/mem/writeback.
//   Stall freezes slots 0-1 and drops a NOP bubble into slot 2.
//   Flush kills slots 0-2. Slots 3.. always shift.
// Ports:
//   clk, rst_n          core clock, async active-low reset
//   if_valid, if_instr  fetch offer ([31:2], low bits implied 2'b11)
//   if_ready            slot 0 accepts (= ~stall & ~flush)
//   stall, flush        hazard controls (flush wins)
//   instr, slot_valid   registered slot contents / valid bits
//   retire_cnt          real instructions leaving the last slot
//   bubble_cnt          bubbles injected by stall or flush

// One pipeline slot: kill beats hold, hold beats load.
module instr_pipe_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        kill,
  input  logic [29:0] d_instr,
  input  logic        d_vld,
  output logic [29:0] q_instr,
  output logic        q_vld
);
  // ADDI x0,x0,0 -> [31:2] = 30'h4, never creates a hazard
  localparam logic [29:0] NOP = 30'h0000_0004;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_instr <= NOP;
      q_vld   <= 1'b0;
    end else if (kill) begin
      q_instr <= NOP;
      q_vld   <= 1'b0;
    end else if (!hold) begin
      q_instr <= d_instr;
      q_vld   <= d_vld;
    end
  end
endmodule

module instr_pipe #(
  parameter int pipeline_length = 4,
  parameter int cnt_width       = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             if_valid,
  input  logic [29:0]                      if_instr,
  output logic                             if_ready,
  input  logic                             stall,
  input  logic                             flush,
  output logic [pipeline_length-1:0][29:0] instr,
  output logic [pipeline_length-1:0]       slot_valid,
  output logic [cnt_width-1:0]             retire_cnt,
  output logic [cnt_width-1:0]             bubble_cnt
);
  localparam logic [29:0] NOP = 30'h0000_0004;

  logic                             accept;
  logic                             bubble_inc;
  logic [pipeline_length-1:0][29:0] d_instr;
  logic [pipeline_length-1:0]       d_vld, hold, kill;

  assign if_ready = ~stall & ~flush;
  assign accept   = if_valid & if_ready;

  // Per-slot steering: which source feeds each slot and how stall/flush act on it.
  for (genvar i = 0; i < pipeline_length; i++) begin : g_slot
    if (i == 0) begin : g_fetch
      assign d_instr[i] = accept ? if_instr : NOP;
      assign d_vld[i]   = accept;
      assign hold[i]    = stall;
      assign kill[i]    = flush;
    end else if (i == 1) begin : g_decode
      assign d_instr[i] = instr[i-1];
      assign d_vld[i]   = slot_valid[i-1];
      assign hold[i]    = stall;
      assign kill[i]    = flush;
    end else if (i == 2) begin : g_bubble
      // Bubble injection point: stall or flush both load a NOP here.
      assign d_instr[i] = instr[i-1];
      assign d_vld[i]   = slot_valid[i-1];
      assign hold[i]    = 1'b0;
      assign kill[i]    = stall | flush;
    end else begin : g_tail
      // Older slots drain unconditionally so the last slot is never held.
      assign d_instr[i] = instr[i-1];
      assign d_vld[i]   = slot_valid[i-1];
      assign hold[i]    = 1'b0;
      assign kill[i]    = 1'b0;
    end

    instr_pipe_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold    (hold[i]),
      .kill    (kill[i]),
      .d_instr (d_instr[i]),
      .d_vld   (d_vld[i]),
      .q_instr (instr[i]),
      .q_vld   (slot_valid[i])
    );
  end

  // A flush only counts a bubble if it displaced a real instruction from decode;
  // a stall always counts, even when decode holds a NOP.
  assign bubble_inc = flush ? slot_valid[1] : stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      retire_cnt <= retire_cnt + cnt_width'(slot_valid[pipeline_length-1]);
      bubble_cnt <= bubble_cnt + cnt_width'(bubble_inc);
    end
  end
endmodule

// File: tb/tb_instr_pipe.sv
module tb_instr_pipe;
  localparam int L = 4;
  localparam logic [29:0] NOP = 30'h4;
  localparam logic [29:0] ADD5 = 30'h0AC; // add x5,x0,x0 = 32'h000002B3

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             if_valid = 1'b0;
  logic [29:0]      if_instr = '0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             if_ready, if_ready_w;
  logic [L-1:0][29:0] instr, instr_w;
  logic [L-1:0]     slot_valid, slot_valid_w;
  logic [31:0]      retire_cnt, bubble_cnt;
  logic [3:0]       retire_cnt_w, bubble_cnt_w;

  instr_pipe #(.pipeline_length(L), .cnt_width(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .stall(stall), .flush(flush), .instr(instr),
    .slot_valid(slot_valid), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, for the wrap check.
  instr_pipe #(.pipeline_length(L), .cnt_width(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready_w), .stall(stall), .flush(flush), .instr(instr_w),
    .slot_valid(slot_valid_w), .retire_cnt(retire_cnt_w), .bubble_cnt(bubble_cnt_w)
  );

  always #5 clk = ~clk;

  typedef struct { logic [29:0] ins; int cyc; } exp_t;
  exp_t sb[$];
  bit   sb_on = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_on && slot_valid[L-1]) begin
      nchk++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL sb_unexpected: got retiring instr %h, required none", instr[L-1]);
      end else begin
        e = sb.pop_front();
        if (instr[L-1] !== e.ins || cyc !== e.cyc + 4) begin
          nerr++;
          $display("FAIL sb_retire: got %h at cyc %0d, required %h at cyc %0d",
                   instr[L-1], cyc, e.ins, e.cyc + 4);
        end
      end
    end
  endtask

  // Offer one fetch this cycle; record it in the scoreboard if accepted.
  task automatic offer(input logic [29:0] v);
    exp_t e;
    if_valid = 1'b1;
    if_instr = v;
    #0;
    if (if_ready) begin
      e.ins = v;
      e.cyc = cyc;
      sb.push_back(e);
    end
    step();
    if_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; if_valid = 1'b0;
    sb.delete();
    sb_on = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (slot_valid != '0 && n < 20) begin
      step();
      n++;
    end
    nchk++;
    if (slot_valid != '0 || sb.size() != 0) begin
      nerr++;
      $display("FAIL drain: slot_valid=%b left=%0d, required 0 and 0", slot_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) offer(30'h300 + 30'(i));
    stall = 1'b1;
    step();
    nchk++;
    if (slot_valid !== 4'b1011 || bubble_cnt !== 32'd1 || retire_cnt !== 32'd1) begin
      nerr++;
      $display("FAIL pre_reset: valid=%b bub=%0d ret=%0d, required 1011 1 1",
               slot_valid, bubble_cnt, retire_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (instr !== {L{NOP}}) begin
      nerr++; $display("FAIL reset_instr: got %h, required all 30'h4", instr);
    end
    nchk++;
    if (slot_valid !== '0) begin
      nerr++; $display("FAIL reset_valid: got %b, required 0", slot_valid);
    end
    nchk++;
    if (retire_cnt !== '0 || bubble_cnt !== '0) begin
      nerr++; $display("FAIL reset_cnt: ret=%0d bub=%0d, required 0 0", retire_cnt, bubble_cnt);
    end
    nchk++;
    if (if_ready !== 1'b0) begin
      nerr++; $display("FAIL reset_if_ready: got %b with stall=1, required 0", if_ready);
    end
    stall = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    sb_on = 1'b1;
    for (int i = 0; i < 10; i++) offer(30'h100 + 30'(i * 7));
    drain();
    nchk++;
    if (retire_cnt !== 32'd10 || bubble_cnt !== 32'd0) begin
      nerr++; $display("FAIL stream_cnt: ret=%0d bub=%0d, required 10 0", retire_cnt, bubble_cnt);
    end
    sb_on = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    offer(ADD5);
    offer(30'h1234567);
    stall = 1'b1;
    if_valid = 1'b1;
    if_instr = 30'h2000001;
    #0;
    nchk++;
    if (if_ready !== 1'b0) begin
      nerr++; $display("FAIL stall_if_ready: got %b, required 0", if_ready);
    end
    for (int k = 1; k <= 2; k++) begin
      step();
      nchk++;
      if (instr[0] !== 30'h1234567 || instr[1] !== ADD5 || slot_valid[1:0] !== 2'b11 ||
          instr[2] !== NOP || slot_valid[2] !== 1'b0 || bubble_cnt !== 32'(k)) begin
        nerr++;
        $display("FAIL stall_hold%0d: s0=%h s1=%h s2=%h v=%b bub=%0d, required 1234567 0ac 4 v=x011 bub=%0d",
                 k, instr[0], instr[1], instr[2], slot_valid, bubble_cnt, k);
      end
    end
    stall = 1'b0;
    step();
    if_valid = 1'b0;
    nchk++;
    if (instr[2] !== ADD5 || slot_valid[2] !== 1'b1 || instr[0] !== 30'h2000001 ||
        bubble_cnt !== 32'd2) begin
      nerr++;
      $display("FAIL stall_release: s2=%h v=%b s0=%h bub=%0d, required 0ac v2=1 2000001 2",
               instr[2], slot_valid, instr[0], bubble_cnt);
    end
    // Stall with an empty decode slot still freezes and counts every cycle.
    do_reset();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) step();
    stall = 1'b0;
    nchk++;
    if (bubble_cnt !== 32'd3 || slot_valid !== '0) begin
      nerr++; $display("FAIL stall_empty: bub=%0d v=%b, required 3 0000", bubble_cnt, slot_valid);
    end
  endtask

  task automatic test_flush(input bit with_stall);
    do_reset();
    for (int i = 0; i < 4; i++) offer(30'h500 + 30'(i));
    flush = 1'b1;
    stall = with_stall;
    if_valid = 1'b1;
    if_instr = 30'h3FFFFFF;
    #0;
    nchk++;
    if (if_ready !== 1'b0) begin
      nerr++; $display("FAIL flush_if_ready(st=%0d): got %b, required 0", with_stall, if_ready);
    end
    step();
    nchk++;
    if (slot_valid !== 4'b1000 || instr[3] !== 30'h501 ||
        instr[2:0] !== {3{NOP}}) begin
      nerr++;
      $display("FAIL flush_slots(st=%0d): v=%b instr=%h, required 1000 with s3=501 rest 4",
               with_stall, slot_valid, instr);
    end
    nchk++;
    if (bubble_cnt !== 32'd1 || retire_cnt !== 32'd1) begin
      nerr++;
      $display("FAIL flush_cnt(st=%0d): bub=%0d ret=%0d, required 1 1", with_stall, bubble_cnt, retire_cnt);
    end
    // A second flush finds decode empty: no bubble counted.
    step();
    flush = 1'b0;
    stall = 1'b0;
    if_valid = 1'b0;
    nchk++;
    if (bubble_cnt !== 32'd1) begin
      nerr++; $display("FAIL flush_empty(st=%0d): bub=%0d, required 1", with_stall, bubble_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sb_on = 1'b1;
    for (int i = 0; i < 17; i++) offer(30'h2000 + 30'(i));
    drain();
    nchk++;
    if (retire_cnt_w !== 4'd1) begin
      nerr++; $display("FAIL wrap_cnt4: got %0d, required 1", retire_cnt_w);
    end
    nchk++;
    if (retire_cnt !== 32'd17) begin
      nerr++; $display("FAIL wrap_cnt32: got %0d, required 17", retire_cnt);
    end
    sb_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush(1'b0);
    test_flush(1'b1);
    test_wrap();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
